// File: rtl/truth_table_checker.sv
// Sweeps all 2^N_IN input vectors, holds each SETTLE_CYCLES+1 cycles, compares dut_y to a latched golden table.
// Latency: done rises 2^N_IN*(SETTLE_CYCLES+1) edges after start is accepted; no backpressure, start ignored while busy.
module truth_table_checker #(
    parameter int N_IN          = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   expected,
    output logic [N_IN-1:0]      vec,
    input  logic                 dut_y,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic [2**N_IN-1:0]   fail_mask
);

    localparam int               NVEC        = 2**N_IN;
    localparam logic [1:0]       IDLE        = 2'd0;
    localparam logic [1:0]       SETTLE      = 2'd1;
    localparam logic [1:0]       SAMPLE      = 2'd2;
    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0]  VEC_LAST    = {N_IN{1'b1}};
    localparam logic [N_IN:0]    ERR_MAX     = {1'b1, {N_IN{1'b0}}};

    logic [1:0]      state;
    logic [7:0]      settle_cnt;
    logic [NVEC-1:0] expected_q;
    logic            mismatch;

    // Case inequality so an X or Z on dut_y is flagged rather than silently matching.
    always_comb begin
        mismatch = (dut_y !== expected_q[vec]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            expected_q <= '0;
            vec        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_mask  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        expected_q <= expected;
                        vec        <= '0;
                        err_count  <= '0;
                        fail_mask  <= '0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                        settle_cnt <= '0;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + 8'd1;
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (mismatch) begin
                        if (err_count != ERR_MAX) begin
                            err_count <= err_count + 1'b1;
                        end
                        fail_mask[vec] <= 1'b1;
                    end
                    if (vec != VEC_LAST) begin
                        vec        <= vec + 1'b1;
                        settle_cnt <= '0;
                        state      <= SETTLE;
                    end else begin
                        // Final vector's own result must be folded into pass.
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && !mismatch;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Scoreboard bench: a 3-input and a 2-input checker instance, each driving a reference gate model.
module tb_truth_table_checker;

    typedef struct {
        logic       pass;
        int         errs;
        logic [7:0] mask;
        int         done_edge;
    } result_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start3, start2;
    logic [7:0] expected3;
    logic [3:0] expected2;
    logic [2:0] vec3;
    logic [1:0] vec2;
    logic       dut_y3, dut_y2;
    logic       busy3, done3, pass3, busy2, done2, pass2;
    logic [3:0] err3;
    logic [2:0] err2;
    logic [7:0] mask3;
    logic [3:0] mask2;
    int         mode;
    int         checks = 0;
    int         errors = 0;
    result_t    sb[$];

    always #5 clk = ~clk;

    // mode 0: OR3, 1: AND3, 2: stuck at 0
    assign dut_y3 = (mode == 0) ? (|vec3) : (mode == 1) ? (&vec3) : 1'b0;
    assign dut_y2 = ^vec2;

    truth_table_checker #(.N_IN(3), .SETTLE_CYCLES(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .expected(expected3), .vec(vec3),
        .dut_y(dut_y3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .fail_mask(mask3)
    );

    truth_table_checker #(.N_IN(2), .SETTLE_CYCLES(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .expected(expected2), .vec(vec2),
        .dut_y(dut_y2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .fail_mask(mask2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 3 is the 2-input XOR
    function automatic logic ref_y(input int m, input int i);
        case (m)
            0:       return i != 0;
            1:       return i == 7;
            3:       return (((i >> 1) ^ i) & 1) != 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic push_expect(input int m, input logic [7:0] tbl, input int nvec, input int done_edge);
        result_t r;
        r.errs = 0;
        r.mask = '0;
        for (int i = 0; i < nvec; i++) begin
            if (ref_y(m, i) != tbl[i]) begin
                r.errs++;
                r.mask[i] = 1'b1;
            end
        end
        r.pass      = (r.errs == 0);
        r.done_edge = done_edge;
        sb.push_back(r);
    endtask

    task automatic pop_compare(input string tag, input int done_edge, input logic p,
                               input int errs, input logic [7:0] mask);
        result_t r;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_sb: got empty scoreboard expected one entry", tag);
            return;
        end
        r = sb.pop_front();
        check({tag, "_done_edge"}, done_edge, r.done_edge);
        check({tag, "_pass"}, 32'(p), 32'(r.pass));
        check({tag, "_err_count"}, errs, r.errs);
        check({tag, "_fail_mask"}, 32'(mask), 32'(r.mask));
    endtask

    task automatic run3(input string tag, input int m, input logic [7:0] tbl, input bit disturb);
        int done_edge = -1;
        int bad_vec   = 0;
        int bad_busy  = 0;
        mode = m;
        @(negedge clk);
        expected3 = tbl;
        start3    = 1'b1;
        push_expect(m, tbl, 8, 24);
        @(posedge clk); #1;
        start3 = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            if (n <= 24 && int'(vec3) != (n - 1) / 3) bad_vec++;
            if (n <= 24 && !busy3) bad_busy++;
            if (disturb) begin
                start3 = (n == 5 || n == 10);
                if (n == 7) expected3 = 8'h00;
            end
            @(posedge clk); #1;
            if (done3) begin
                done_edge = n;
                break;
            end
        end
        start3 = 1'b0;
        pop_compare(tag, done_edge, pass3, int'(err3), mask3);
        check({tag, "_vec_step"}, bad_vec, 0);
        check({tag, "_busy_during"}, bad_busy, 0);
        check({tag, "_busy_end"}, 32'(busy3), 0);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_vec_hold"}, 32'(vec3), 7);
        check({tag, "_done_hold"}, 32'(done3), 1);
    endtask

    task automatic run2(input string tag, input logic [3:0] tbl);
        int done_edge = -1;
        @(negedge clk);
        expected2 = tbl;
        start2    = 1'b1;
        push_expect(3, {4'h0, tbl}, 4, 8);
        @(posedge clk); #1;
        start2 = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done2) begin
                done_edge = n;
                break;
            end
        end
        pop_compare(tag, done_edge, pass2, int'(err2), {4'h0, mask2});
        check({tag, "_vec_end"}, 32'(vec2), 3);
    endtask

    initial begin
        rst_n     = 1'b1;
        start3    = 1'b0;
        start2    = 1'b0;
        expected3 = 8'h00;
        expected2 = 4'h0;
        mode      = 0;
        #2 rst_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset3", 32'({busy3, done3, pass3, err3, mask3, vec3}), 0);
        check("reset2", 32'({busy2, done2, pass2, err2, mask2, vec2}), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle3", 32'({busy3, done3, pass3, err3, mask3, vec3}), 0);

        run3("or3", 0, 8'hFE, 1'b0);
        run3("stuck0", 2, 8'hFE, 1'b0);
        run3("and3", 1, 8'hFE, 1'b0);
        run3("or3_disturb", 0, 8'hFE, 1'b1);

        // Abort a stuck-at-0 sweep at edge 12, after four vectors were sampled.
        mode = 2;
        @(negedge clk);
        expected3 = 8'hFE;
        start3    = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("pre_rst_err", 32'(err3), 3);
        check("pre_rst_mask", 32'(mask3), 32'h0E);
        rst_n = 1'b0;
        #1;
        check("async_rst", 32'({busy3, done3, pass3, err3, mask3, vec3}), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        check("post_rst", 32'({busy3, done3, pass3, err3, mask3, vec3}), 0);
        run3("after_rst", 0, 8'hFE, 1'b0);

        run2("xor2", 4'h6);
        run2("xor2_all_bad", 4'h9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/truth_table_checker.md
TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

Interface
REQ-001 SHALL have parameter N_IN, default 3: number of DUT inputs; legal range 1..6.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2: cycles a vector is held before its output is sampled; legal range 1..255.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: request to begin a sweep; sampled in IDLE only.
REQ-006 SHALL have port expected, input, 2^N_IN: golden truth table; bit i is the expected y for input vector i.
REQ-007 SHALL have port vec, output, N_IN: stimulus to the DUT inputs, MSB = first DUT input (a), LSB = last (c).
REQ-008 SHALL have port dut_y, input, 1: DUT output under test.
REQ-009 SHALL have port busy, output, 1: high while a sweep is in progress.
REQ-010 SHALL have port done, output, 1: high from sweep completion until the next accepted start or reset.
REQ-011 SHALL have port pass, output, 1: valid while done is high; 1 = zero mismatches.
REQ-012 SHALL have port err_count, output, N_IN+1: number of mismatching vectors in the last sweep.
REQ-013 SHALL have port fail_mask, output, 2^N_IN: bit i is set if vector i mismatched.

Function
REQ-014 SHALL implement the FSM states IDLE, SETTLE and SAMPLE.
REQ-015 IDLE with start=1 SHALL, on the same edge: latch expected internally; set vec=0; clear err_count, fail_mask, done and pass; set busy=1; clear the settle counter; go to SETTLE.
REQ-016 SETTLE SHALL increment the settle counter each cycle and go to SAMPLE on the edge where the counter equals SETTLE_CYCLES-1.
REQ-017 SAMPLE SHALL compare dut_y with latched expected[vec]; on a mismatch it SHALL increment err_count and set fail_mask[vec] on the same edge.
REQ-018 SAMPLE with vec < 2^N_IN-1 SHALL increment vec, clear the settle counter and return to SETTLE.
REQ-019 SAMPLE with vec = 2^N_IN-1 SHALL go to IDLE, clear busy, set done=1, and set pass=1 only if no mismatch occurred, including the final vector.
REQ-020 Each vector SHALL be held for exactly SETTLE_CYCLES+1 cycles; done SHALL rise exactly 2^N_IN*(SETTLE_CYCLES+1) edges after the start-accept edge.
REQ-021 Following REQ-019, vec SHALL hold 2^N_IN-1 after completion and SHALL not wrap.
REQ-022 start while busy=1 SHALL be ignored, with no restart and no effect on counts.
REQ-023 Changes on expected during a sweep SHALL have no effect; only the value latched at start is used.
REQ-024 start held high continuously SHALL begin a new sweep on the first edge in IDLE after completion; that edge clears done.
REQ-025 dut_y of X or Z SHALL count as a mismatch in simulation.
REQ-026 err_count SHALL saturate at 2^N_IN and SHALL not overflow.

Reset
REQ-027 rst_n=0 SHALL immediately force: state IDLE, vec=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0, settle counter 0.
REQ-028 Reset asserted mid-sweep SHALL abort the sweep with no partial result retained; the first start after release SHALL begin a full sweep from vec=0.

Verification
REQ-029 Bench SHALL cover: defaults, OR3 DUT, expected=8'hFE, pulse start -> done at edge 24, pass=1, err_count=0, fail_mask=8'h00, vec stepping 0..7 with each value held 3 cycles.
REQ-030 Bench SHALL cover: dut_y stuck at 0, expected=8'hFE -> pass=0, err_count=7, fail_mask=8'hFE.
REQ-031 Bench SHALL cover: AND3 DUT, expected=8'hFE -> pass=0, err_count=6, fail_mask=8'h7E.
REQ-032 Bench SHALL cover: start pulsed at edges 5 and 10 of a sweep, and expected changed to 8'h00 mid-sweep -> result identical to REQ-029, done still at edge 24.
REQ-033 Bench SHALL cover: rst_n low at edge 12 for 2 cycles -> all outputs 0 asynchronously; a new start yields the REQ-029 result 24 edges later.
REQ-034 Bench SHALL cover: N_IN=2, SETTLE_CYCLES=1, XOR DUT, expected=4'h6 -> done at edge 8, pass=1, err_count width 3.
